ehl_ahb_slave_arbiter: RTL and testbench
========================================

Name: ehl_ahb_slave_arbiter

Overview:
Per-slave-port arbiter for the AHB matrix. It decides which master owns the slave's address phase and tracks which master owns the data phase. It keeps ownership for the whole of a fixed-length burst, and for undefined-length INCR bursts up to a beat limit. The matrix instantiates one per slave and uses grant/downer to steer os_* mux selects, om_hready/om_hrdata/om_hresp return paths and wait-state insertion for losing masters.

Parameters:
MNUM, 2, number of masters (1..16)
PRIO_MODE, 0, 0 = round-robin, 1 = fixed priority (master 0 highest)
INCR_MAX, 16, max beats an INCR (undefined-length) owner keeps the port while others request; 0 = unlimited
MIDX_W, $clog2(MNUM) (min 1), width of index outputs (derived, not overridden)

Ports:
hclk  input  1  AHB clock
hresetn  input  1  asynchronous active-low reset
m_req  input  MNUM  master i presents htrans[1]=1 decoded to this slave and allowed by im_route
m_htrans  input  2*MNUM  per-master htrans, packed, master 0 in LSBs
m_hburst  input  3*MNUM  per-master hburst, packed
s_hready  input  1  slave hreadyout (transfer boundary)
s_hresp  input  1  slave hresp[0] (1 = ERROR)
grant  output  MNUM  one-hot address-phase owner; all-zero = port idle
grant_idx  output  MIDX_W  binary index of grant (0 when idle)
downer  output  MNUM  one-hot data-phase owner
dvalid  output  1  a data phase is in progress on this slave
m_wait  output  MNUM  m_req[i] & ~grant[i]; matrix forces master i hready low

Behaviour:
- Interface: one clock hclk; reset hresetn is asynchronous, active-low.
- Reset values:
  - grant=0, grant_idx=0, downer=0, dvalid=0, m_wait=m_req (combinational).
  - Internal rr_ptr=0, beat_cnt=0, locked=0.
- Update rule: grant, downer, dvalid and the counters update only on posedge hclk with s_hready=1. With s_hready=0 all state holds, including during the first ERROR cycle.
- Arbitration (when not locked):
  - next = first requester in m_req, searched from rr_ptr upward with wrap (PRIO_MODE=0) or from index 0 (PRIO_MODE=1).
  - grant<=onehot(next).
  - No requester: grant<=0.
  - rr_ptr<=next+1 mod MNUM when a grant is issued.
- Latency: m_req rising with s_hready=1 and port free gives grant at the next edge. The matrix drives that master's address to the slave in the cycle grant is high.
- Burst lock, entered when a granted master's m_htrans=NONSEQ and hburst!=SINGLE while s_hready=1:
  - Fixed bursts: INCR4/WRAP4 lock 4 beats, INCR8/WRAP8 lock 8, INCR16/WRAP16 lock 16.
  - beat_cnt counts accepted NONSEQ/SEQ beats. The lock releases after the last beat is accepted.
  - INCR: locked until the owner drives IDLE or NONSEQ.
  - INCR: if INCR_MAX!=0 and another master requests, the lock releases after INCR_MAX beats.
  - BUSY beats hold the lock and do not count.
  - Owner driving IDLE mid-burst (early termination) releases immediately.
- ERROR: s_hresp=1 with s_hready=1 (second error cycle) releases the lock. Rearbitration happens at that edge.
- Data phase: at each s_hready=1 edge:
  - dvalid<=|grant & htrans_of_owner[1], downer<=grant.
  - Otherwise dvalid<=0, downer<=0.
- Simultaneous events: a lock release and a new request in the same edge are resolved in that edge; no dead cycle.
- A master deasserting m_req while waiting is simply skipped.
- Reset mid-burst aborts everything; no partial state survives.

Decomposition:
- Shared package constants: HTRANS_IDLE/BUSY/NONSEQ/SEQ, HBURST_* encodings, a burst_len function (hburst -> 1/4/8/16/0).
- One sub-module, ehl_rr_pick: combinational round-robin/fixed priority picker (req, ptr, mode -> onehot, idx). It is reused by later matrix arbiters.

Test Plan:
- Reset: hold hresetn=0 with m_req=2'b11 -> grant=0, dvalid=0, m_wait=2'b11. Release -> grant=2'b01 at first edge.
- Round-robin: m_req=2'b11 with SINGLE NONSEQ continuously and s_hready=1 -> grant alternates 01,10,01,10; downer lags grant by one cycle.
- Burst lock: M0 issues INCR4 at the same time M1 requests -> grant=01 for 4 accepted beats. With s_hready low 2 cycles on beat 2, M1 is granted at the edge after beat 4; m_wait[1]=1 throughout.
- INCR limit: INCR_MAX=4, M0 issues INCR for 10 beats, M1 requests -> M1 granted after M0's 4th beat. Alone, M0 holds 10 beats.
- Error/early termination: slave returns 2-cycle ERROR on beat 2 of M1 INCR8 -> grant stays during the first cycle and switches to M0 at the second. Separately, M0 driving IDLE after beat 3 of WRAP8 -> released next edge.
- Fixed priority: PRIO_MODE=1 with m_req=2'b11 SINGLE transfers continuously -> grant stays 01; M1 is granted only when m_req[0]=0.

Source files
------------

// File: rtl/ehl_ahb_slave_arbiter_pkg.sv
// Shared AHB encodings and burst helpers for the slave-port arbiters.
package ehl_ahb_slave_arbiter_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;
  localparam logic [2:0] HBURST_WRAP4  = 3'd2;
  localparam logic [2:0] HBURST_INCR4  = 3'd3;
  localparam logic [2:0] HBURST_WRAP8  = 3'd4;
  localparam logic [2:0] HBURST_INCR8  = 3'd5;
  localparam logic [2:0] HBURST_WRAP16 = 3'd6;
  localparam logic [2:0] HBURST_INCR16 = 3'd7;

  // Beats in a burst; 0 marks undefined-length INCR.
  function automatic logic [4:0] burst_len(input logic [2:0] hburst);
    logic [4:0] len;
    case (hburst)
      HBURST_SINGLE:               len = 5'd1;
      HBURST_INCR:                 len = 5'd0;
      HBURST_WRAP4, HBURST_INCR4:  len = 5'd4;
      HBURST_WRAP8, HBURST_INCR8:  len = 5'd8;
      HBURST_WRAP16, HBURST_INCR16: len = 5'd16;
      default:                     len = 5'd1;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/ehl_rr_pick.sv
// Combinational requester picker: round-robin from ptr_i, or fixed priority from index 0.
module ehl_rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  input  logic             mode_i,
  output logic [N-1:0]     onehot_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  int cand;

  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    cand     = 0;
    for (int k = 0; k < N; k++) begin
      cand = (mode_i ? 0 : int'(ptr_i)) + k;
      if (cand >= N) cand = cand - N;
      if (!any_o && req_i[cand]) begin
        any_o          = 1'b1;
        onehot_o[cand] = 1'b1;
        idx_o          = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/ehl_ahb_slave_arbiter.sv
// Per-slave AHB arbiter: address-phase grant with burst lock, plus data-phase owner tracking.
module ehl_ahb_slave_arbiter
  import ehl_ahb_slave_arbiter_pkg::*;
#(
  parameter int MNUM      = 2,
  parameter int PRIO_MODE = 0,
  parameter int INCR_MAX  = 16,
  localparam int MIDX_W   = (MNUM > 1) ? $clog2(MNUM) : 1
) (
  input  logic                hclk,
  input  logic                hresetn,
  input  logic [MNUM-1:0]     m_req,
  input  logic [2*MNUM-1:0]   m_htrans,
  input  logic [3*MNUM-1:0]   m_hburst,
  input  logic                s_hready,
  input  logic                s_hresp,
  output logic [MNUM-1:0]     grant,
  output logic [MIDX_W-1:0]   grant_idx,
  output logic [MNUM-1:0]     downer,
  output logic                dvalid,
  output logic [MNUM-1:0]     m_wait
);

  localparam int CNT_MAX = (INCR_MAX > 16) ? INCR_MAX : 16;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic [MNUM-1:0]   grant_q, grant_d, downer_q, downer_d;
  logic [MIDX_W-1:0] gidx_q, gidx_d, rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [4:0]        lock_len_q, lock_len_d;
  logic              locked_q, locked_d, dvalid_q, dvalid_d;

  logic [MNUM-1:0]   pick_oh;
  logic [MIDX_W-1:0] pick_idx;
  logic              pick_any;
  logic [1:0]        own_htrans;
  logic [2:0]        own_hburst;
  logic              others, keep;

  ehl_rr_pick #(.N(MNUM), .IDX_W(MIDX_W)) u_pick (
    .req_i    (m_req),
    .ptr_i    (rr_ptr_q),
    .mode_i   (PRIO_MODE != 0),
    .onehot_o (pick_oh),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  always_comb begin
    own_htrans = m_htrans[2*int'(gidx_q) +: 2];
    own_hburst = m_hburst[3*int'(gidx_q) +: 3];
    others     = |(m_req & ~grant_q);
  end

  always_comb begin
    grant_d    = grant_q;
    gidx_d     = gidx_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    lock_len_d = lock_len_q;
    keep       = 1'b0;

    dvalid_d = (|grant_q) & own_htrans[1];
    downer_d = dvalid_d ? grant_q : '0;

    // A fresh NONSEQ burst (re)starts the lock even if an INCR lock was running.
    if (|grant_q) begin
      case (own_htrans)
        HTRANS_NONSEQ: begin
          if (own_hburst != HBURST_SINGLE) begin
            keep       = 1'b1;
            lock_len_d = burst_len(own_hburst);
            beat_cnt_d = CNT_W'(1);
          end
        end
        HTRANS_SEQ: begin
          keep = locked_q;
          if (beat_cnt_q != {CNT_W{1'b1}}) beat_cnt_d = beat_cnt_q + 1'b1;
        end
        HTRANS_BUSY: keep = locked_q;
        HTRANS_IDLE: keep = 1'b0;
        default:     keep = 1'b0;
      endcase
      if (keep && own_htrans[1]) begin
        if (lock_len_d != 5'd0)
          keep = beat_cnt_d < CNT_W'(lock_len_d);
        else if (INCR_MAX != 0 && others)
          keep = beat_cnt_d < CNT_W'(INCR_MAX);
      end
    end
    if (s_hresp) keep = 1'b0;

    locked_d = keep;
    if (!keep) begin
      beat_cnt_d = '0;
      lock_len_d = '0;
      grant_d    = pick_oh;
      gidx_d     = pick_any ? pick_idx : '0;
      if (pick_any)
        rr_ptr_d = (pick_idx == MIDX_W'(MNUM - 1)) ? '0 : pick_idx + 1'b1;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      grant_q    <= '0;
      gidx_q     <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      lock_len_q <= '0;
      locked_q   <= 1'b0;
      downer_q   <= '0;
      dvalid_q   <= 1'b0;
    end else if (s_hready) begin
      grant_q    <= grant_d;
      gidx_q     <= gidx_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      lock_len_q <= lock_len_d;
      locked_q   <= locked_d;
      downer_q   <= downer_d;
      dvalid_q   <= dvalid_d;
    end
  end

  assign grant     = grant_q;
  assign grant_idx = gidx_q;
  assign downer    = downer_q;
  assign dvalid    = dvalid_q;
  assign m_wait    = m_req & ~grant_q;

endmodule

// File: tb/tb_ehl_ahb_slave_arbiter.sv
// Directed-vector bench for ehl_ahb_slave_arbiter with a queue-based scoreboard.
module tb_ehl_ahb_slave_arbiter;
  import ehl_ahb_slave_arbiter_pkg::*;

  localparam logic [1:0] ID = HTRANS_IDLE;
  localparam logic [1:0] NS = HTRANS_NONSEQ;
  localparam logic [1:0] SQ = HTRANS_SEQ;
  localparam logic [2:0] SG = HBURST_SINGLE;
  localparam logic [2:0] IC = HBURST_INCR;
  localparam logic [2:0] I4 = HBURST_INCR4;
  localparam logic [2:0] W8 = HBURST_WRAP8;
  localparam logic [2:0] I8 = HBURST_INCR8;

  logic       hclk = 1'b0;
  logic       hresetn = 1'b0;
  logic [1:0] m_req = 2'b00;
  logic [3:0] m_htrans = 4'b0;
  logic [5:0] m_hburst = 6'b0;
  logic       s_hready = 1'b1;
  logic       s_hresp = 1'b0;

  logic [1:0] grant, downer, m_wait;
  logic       grant_idx, dvalid;
  logic [1:0] grant_fp, downer_fp, m_wait_fp;
  logic       grant_idx_fp, dvalid_fp;

  ehl_ahb_slave_arbiter #(.MNUM(2), .PRIO_MODE(0), .INCR_MAX(4)) dut (
    .hclk(hclk), .hresetn(hresetn), .m_req(m_req), .m_htrans(m_htrans),
    .m_hburst(m_hburst), .s_hready(s_hready), .s_hresp(s_hresp),
    .grant(grant), .grant_idx(grant_idx), .downer(downer), .dvalid(dvalid),
    .m_wait(m_wait)
  );

  ehl_ahb_slave_arbiter #(.MNUM(2), .PRIO_MODE(1), .INCR_MAX(16)) dut_fp (
    .hclk(hclk), .hresetn(hresetn), .m_req(m_req), .m_htrans(m_htrans),
    .m_hburst(m_hburst), .s_hready(s_hready), .s_hresp(s_hresp),
    .grant(grant_fp), .grant_idx(grant_idx_fp), .downer(downer_fp), .dvalid(dvalid_fp),
    .m_wait(m_wait_fp)
  );

  always #5 hclk = ~hclk;

  typedef struct {
    int         num;
    logic [1:0] grant;
    logic       gidx;
    logic [1:0] downer;
    logic       dvalid;
    logic [1:0] mwait;
    logic       chk_fp;
    logic [1:0] fp;
    logic [1:0] fp_wait;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_push = 0;

  // Drives one cycle of inputs and queues the outputs expected during that cycle.
  task automatic vec(input logic rstn, input logic [1:0] req,
                     input logic [1:0] t0, input logic [2:0] b0,
                     input logic [1:0] t1, input logic [2:0] b1,
                     input logic rdy, input logic resp,
                     input logic [1:0] eg, input logic [1:0] ed, input logic edv,
                     input logic chk, input logic [1:0] efp);
    exp_t e;
    @(posedge hclk);
    #1;
    hresetn  = rstn;
    m_req    = req;
    m_htrans = {t1, t0};
    m_hburst = {b1, b0};
    s_hready = rdy;
    s_hresp  = resp;
    n_push++;
    e.num     = n_push;
    e.grant   = eg;
    e.gidx    = eg[1];
    e.downer  = ed;
    e.dvalid  = edv;
    e.mwait   = req & ~eg;
    e.chk_fp  = chk;
    e.fp      = efp;
    e.fp_wait = req & ~efp;
    exp_q.push_back(e);
  endtask

  task automatic v(input logic rstn, input logic [1:0] req,
                   input logic [1:0] t0, input logic [2:0] b0,
                   input logic [1:0] t1, input logic [2:0] b1,
                   input logic rdy, input logic resp,
                   input logic [1:0] eg, input logic [1:0] ed, input logic edv);
    vec(rstn, req, t0, b0, t1, b1, rdy, resp, eg, ed, edv, 1'b0, 2'b00);
  endtask

  initial begin : monitor
    exp_t e;
    logic bad;
    forever begin
      @(negedge hclk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        bad = (grant !== e.grant) || (grant_idx !== e.gidx) || (downer !== e.downer) ||
              (dvalid !== e.dvalid) || (m_wait !== e.mwait) ||
              (e.chk_fp && ((grant_fp !== e.fp) || (grant_idx_fp !== e.fp[1]) ||
                            (m_wait_fp !== e.fp_wait)));
        if (bad) begin
          n_err++;
          $display("FAIL vec%0d: got grant=%b idx=%b downer=%b dvalid=%b m_wait=%b fp_grant=%b fp_wait=%b ; want grant=%b idx=%b downer=%b dvalid=%b m_wait=%b fp_grant=%b(chk=%b)",
                   e.num, grant, grant_idx, downer, dvalid, m_wait, grant_fp, m_wait_fp,
                   e.grant, e.gidx, e.downer, e.dvalid, e.mwait, e.fp, e.chk_fp);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: run did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    // Reset held with both masters requesting, then release.
    vec(0, 2'b11, NS, SG, NS, SG, 1, 0, 2'b00, 2'b00, 0, 1, 2'b00);
    vec(0, 2'b11, NS, SG, NS, SG, 1, 0, 2'b00, 2'b00, 0, 1, 2'b00);
    vec(1, 2'b11, NS, SG, NS, SG, 1, 0, 2'b00, 2'b00, 0, 1, 2'b00);
    // Round-robin alternation vs fixed priority on continuous SINGLE traffic.
    vec(1, 2'b11, NS, SG, NS, SG, 1, 0, 2'b01, 2'b00, 0, 1, 2'b01);
    vec(1, 2'b11, NS, SG, NS, SG, 1, 0, 2'b10, 2'b01, 1, 1, 2'b01);
    vec(1, 2'b11, NS, SG, NS, SG, 1, 0, 2'b01, 2'b10, 1, 1, 2'b01);
    vec(1, 2'b11, NS, SG, NS, SG, 1, 0, 2'b10, 2'b01, 1, 1, 2'b01);
    vec(1, 2'b10, ID, SG, NS, SG, 1, 0, 2'b01, 2'b10, 1, 1, 2'b01);
    vec(1, 2'b10, ID, SG, NS, SG, 1, 0, 2'b10, 2'b00, 0, 1, 2'b10);
    vec(1, 2'b11, NS, I4, NS, SG, 1, 0, 2'b10, 2'b10, 1, 1, 2'b10);
    // INCR4 lock with two wait states on beat 2; M1 waits throughout.
    v(1, 2'b11, NS, I4, NS, SG, 1, 0, 2'b01, 2'b10, 1);
    v(1, 2'b11, SQ, I4, NS, SG, 0, 0, 2'b01, 2'b01, 1);
    v(1, 2'b11, SQ, I4, NS, SG, 0, 0, 2'b01, 2'b01, 1);
    v(1, 2'b11, SQ, I4, NS, SG, 1, 0, 2'b01, 2'b01, 1);
    v(1, 2'b11, SQ, I4, NS, SG, 1, 0, 2'b01, 2'b01, 1);
    v(1, 2'b11, SQ, I4, NS, SG, 1, 0, 2'b01, 2'b01, 1);
    v(1, 2'b10, ID, SG, NS, SG, 1, 0, 2'b10, 2'b01, 1);
    v(1, 2'b00, ID, SG, ID, SG, 1, 0, 2'b10, 2'b10, 1);
    v(1, 2'b00, ID, SG, ID, SG, 1, 0, 2'b00, 2'b00, 0);
    // INCR alone: held for all 10 beats, released on IDLE.
    v(1, 2'b01, NS, IC, ID, SG, 1, 0, 2'b00, 2'b00, 0);
    v(1, 2'b01, NS, IC, ID, SG, 1, 0, 2'b01, 2'b00, 0);
    for (int i = 0; i < 9; i++)
      v(1, 2'b01, SQ, IC, ID, SG, 1, 0, 2'b01, 2'b01, 1);
    v(1, 2'b00, ID, IC, ID, SG, 1, 0, 2'b01, 2'b01, 1);
    v(1, 2'b00, ID, SG, ID, SG, 1, 0, 2'b00, 2'b00, 0);
    // INCR with a competing request: released after 4 beats.
    v(1, 2'b01, NS, IC, ID, SG, 1, 0, 2'b00, 2'b00, 0);
    v(1, 2'b11, NS, IC, NS, SG, 1, 0, 2'b01, 2'b00, 0);
    for (int i = 0; i < 3; i++)
      v(1, 2'b11, SQ, IC, NS, SG, 1, 0, 2'b01, 2'b01, 1);
    v(1, 2'b11, SQ, IC, NS, SG, 1, 0, 2'b10, 2'b01, 1);
    v(1, 2'b00, ID, IC, ID, SG, 1, 0, 2'b01, 2'b10, 1);
    v(1, 2'b00, ID, SG, ID, SG, 1, 0, 2'b00, 2'b00, 0);
    // Two-cycle ERROR on beat 2 of M1 INCR8.
    v(1, 2'b10, ID, SG, NS, I8, 1, 0, 2'b00, 2'b00, 0);
    v(1, 2'b11, NS, SG, NS, I8, 1, 0, 2'b10, 2'b00, 0);
    v(1, 2'b11, NS, SG, SQ, I8, 1, 0, 2'b10, 2'b10, 1);
    v(1, 2'b11, NS, SG, SQ, I8, 0, 1, 2'b10, 2'b10, 1);
    v(1, 2'b11, NS, SG, SQ, I8, 1, 1, 2'b10, 2'b10, 1);
    v(1, 2'b01, NS, SG, ID, I8, 1, 0, 2'b01, 2'b10, 1);
    v(1, 2'b00, ID, SG, ID, SG, 1, 0, 2'b01, 2'b01, 1);
    v(1, 2'b00, ID, SG, ID, SG, 1, 0, 2'b00, 2'b00, 0);
    // Early termination of WRAP8 after beat 3.
    v(1, 2'b01, NS, W8, ID, SG, 1, 0, 2'b00, 2'b00, 0);
    v(1, 2'b11, NS, W8, NS, SG, 1, 0, 2'b01, 2'b00, 0);
    v(1, 2'b11, SQ, W8, NS, SG, 1, 0, 2'b01, 2'b01, 1);
    v(1, 2'b11, SQ, W8, NS, SG, 1, 0, 2'b01, 2'b01, 1);
    v(1, 2'b10, ID, W8, NS, SG, 1, 0, 2'b01, 2'b01, 1);
    v(1, 2'b10, ID, SG, NS, SG, 1, 0, 2'b10, 2'b00, 0);
    v(1, 2'b00, ID, SG, ID, SG, 1, 0, 2'b10, 2'b10, 1);
    v(1, 2'b00, ID, SG, ID, SG, 1, 0, 2'b00, 2'b00, 0);
    // Reset in the middle of a burst clears grant and the round-robin pointer.
    v(1, 2'b01, NS, I4, ID, SG, 1, 0, 2'b00, 2'b00, 0);
    v(1, 2'b01, NS, I4, ID, SG, 1, 0, 2'b01, 2'b00, 0);
    v(0, 2'b01, SQ, I4, ID, SG, 1, 0, 2'b00, 2'b00, 0);
    v(1, 2'b11, NS, SG, NS, SG, 1, 0, 2'b00, 2'b00, 0);
    v(1, 2'b00, ID, SG, ID, SG, 1, 0, 2'b01, 2'b00, 0);
    v(1, 2'b00, ID, SG, ID, SG, 1, 0, 2'b00, 2'b00, 0);

    repeat (2) @(posedge hclk);
    #1;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected entries left unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
